// File: rtl/adder_accum_seq.sv
// ============================================================================
//  Module   : adder_accum_seq
//  Purpose  : Multi-term accumulation sequencer wrapped around a registered adder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_accum_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       f_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_i,
  input  logic             op_last_i,
  output logic [1:0]       add_f_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  input  logic [WIDTH-1:0] add_y_i,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ADD    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_f;
  logic             r_last;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_f     <= 2'd0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (op_valid_i) begin
            // First term bypasses the adder so a ones'-complement +0 never enters the sum.
            r_acc   <= op_i;
            r_f     <= (f_i == 2'd3) ? 2'd0 : f_i;
            r_err   <= (f_i == 2'd3);
            r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_ACCEPT: begin
          if (op_valid_i) begin
            r_b    <= op_i;
            r_last <= op_last_i;
            if (r_count != {CNT_W{1'b1}}) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_acc <= add_y_i;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (op_valid_i) w_next = op_last_i ? S_DONE : S_ACCEPT;
      S_ACCEPT: if (op_valid_i) w_next = S_ADD;
      S_ADD:    w_next = S_WAIT;
      S_WAIT:   w_next = r_last ? S_DONE : S_ACCEPT;
      S_DONE:   if (sum_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign op_ready_o  = (r_state == S_IDLE) || (r_state == S_ACCEPT);
  assign sum_valid_o = (r_state == S_DONE);
  assign sum_o       = r_acc;
  assign add_a_o     = r_acc;
  assign add_b_o     = r_b;
  assign add_f_o     = r_f;
  assign count_o     = r_count;
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adder_accum_seq.sv
// ============================================================================
//  Module   : tb_adder_accum_seq
//  Purpose  : Directed scoreboard bench for adder_accum_seq with a registered adder model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_accum_seq;

  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   f_i;
  logic         op_valid_i;
  logic         op_ready_o;
  logic [W-1:0] op_i;
  logic         op_last_i;
  logic [1:0]   add_f_o;
  logic [W-1:0] add_a_o;
  logic [W-1:0] add_b_o;
  logic [W-1:0] add_y_i;
  logic         sum_valid_o;
  logic         sum_ready_i;
  logic [W-1:0] sum_o;
  logic [C-1:0] count_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic [C-1:0] cnt;
    logic         err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  adder_accum_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .f_i(f_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i), .op_last_i(op_last_i),
    .add_f_o(add_f_o), .add_a_o(add_a_o), .add_b_o(add_b_o), .add_y_i(add_y_i),
    .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i), .sum_o(sum_o),
    .count_o(count_o), .err_o(err_o)
  );

  function automatic logic [W-1:0] mdl(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] f);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (f == 2'd1) return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    return s[W-1:0];
  endfunction

  // Registered adder the sequencer drives; one-cycle latency, shares rst.
  always_ff @(posedge clk) begin
    if (rst) add_y_i <= '0;
    else     add_y_i <= mdl(add_a_o, add_b_o, add_f_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] f, input logic [W-1:0] v, input logic last);
    int n;
    @(negedge clk);
    f_i = f; op_i = v; op_last_i = last; op_valid_i = 1'b1;
    n = 0;
    while (!op_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    op_valid_i = 1'b0; op_last_i = 1'b0;
  endtask

  task automatic send_seq(input logic [1:0] f, input int n,
                          input logic [W-1:0] t0, input logic [W-1:0] t1, input logic [W-1:0] t2);
    logic [W-1:0] t[3];
    logic [1:0]   fm;
    exp_t         e;
    t[0] = t0; t[1] = t1; t[2] = t2;
    fm = (f == 2'd3) ? 2'd0 : f;
    e.sum = t[0];
    for (int i = 1; i < n; i++) e.sum = mdl(e.sum, t[i], fm);
    e.cnt = C'(n);
    e.err = (f == 2'd3);
    sb.push_back(e);
    for (int i = 0; i < n; i++) send(f, t[i], i == n - 1);
  endtask

  task automatic receive(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!sum_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum_o), 32'(e.sum));
      check({tag, "_count"}, 32'(count_o), 32'(e.cnt));
      check({tag, "_err"}, 32'(err_o), 32'(e.err));
    end
    sum_ready_i = 1'b1;
    @(posedge clk);
    #1;
    sum_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(sum_valid_o), 32'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; f_i = 2'd0; op_valid_i = 1'b0; op_i = '0; op_last_i = 1'b0; sum_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(op_ready_o), 32'd1);
    check("rst_valid", 32'(sum_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_a", 32'(add_a_o), 32'd0);
    check("rst_b", 32'(add_b_o), 32'd0);
    check("rst_f", 32'(add_f_o), 32'd0);

    // 3+5+7: valid after ADD and WAIT, i.e. visible two edges after the accepting edge.
    send_seq(2'd0, 3, 4'd3, 4'd5, 4'd7);
    @(negedge clk); check("lat_add", 32'(sum_valid_o), 32'd0);
    check("lat_add_ready", 32'(op_ready_o), 32'd0);
    @(negedge clk); check("lat_wait", 32'(sum_valid_o), 32'd0);
    @(negedge clk); check("lat_done", 32'(sum_valid_o), 32'd1);
    receive("seq357");

    send_seq(2'd0, 2, 4'd9, 4'd9, 4'd0);
    receive("seq99");
    send_seq(2'd2, 2, 4'hD, 4'h2, 4'd0);
    receive("twos");
    send_seq(2'd1, 2, 4'hE, 4'h3, 4'd0);
    receive("ones");

    // Single term: done on the next cycle, held operand register untouched.
    send_seq(2'd0, 1, 4'hA, 4'd0, 4'd0);
    @(negedge clk);
    check("single_valid", 32'(sum_valid_o), 32'd1);
    check("single_b_hold", 32'(add_b_o), 32'h3);
    check("single_a", 32'(add_a_o), 32'hA);
    receive("single");

    // Illegal function code plus backpressure.
    send_seq(2'd3, 2, 4'd1, 4'd1, 4'd0);
    repeat (3) @(negedge clk);
    held = sum_o;
    check("ill_f", 32'(add_f_o), 32'd0);
    check("ill_err", 32'(err_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(sum_valid_o), 32'd1);
      check("bp_sum", 32'(sum_o), 32'(held));
      check("bp_ready", 32'(op_ready_o), 32'd0);
    end
    receive("illegal");
    check("hold_count", 32'(count_o), 32'd2);
    check("hold_err", 32'(err_o), 32'd1);

    // Reset landing on the ADD cycle of an unfinished three-term sequence.
    send(2'd0, 4'd1, 1'b0);
    send(2'd0, 4'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(op_ready_o), 32'd1);
    check("mid_rst_valid", 32'(sum_valid_o), 32'd0);
    check("mid_rst_count", 32'(count_o), 32'd0);
    send_seq(2'd0, 2, 4'd1, 4'd2, 4'd0);
    receive("after_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_accum_seq.md
Name: adder_accum_seq

Overview:
Multi-term accumulation sequencer that sits directly in front of the registered `adder` stage and also consumes its result.
- Accepts a stream of operands with a valid/ready handshake and a `last` marker.
- Drives the adder's `f_i`/`a_i`/`b_i` with the running sum and the next operand, then captures `y_o` one cycle later.
- Presents the final sum on a valid/ready output port.

Parameters:
- WIDTH, 4, operand/sum width; must match the connected adder's WIDTH.
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- f_i  input  2  function code, sampled only when the first term of a sequence is accepted
- op_valid_i  input  1  operand valid
- op_ready_o  output  1  sequencer can accept an operand
- op_i  input  WIDTH  operand
- op_last_i  input  1  operand is the final term of the sequence
- add_f_o  output  2  to adder f_i
- add_a_o  output  WIDTH  to adder a_i (running sum)
- add_b_o  output  WIDTH  to adder b_i (held operand)
- add_y_i  input  WIDTH  from adder y_o (registered, 1-cycle latency)
- sum_valid_o  output  1  final sum valid
- sum_ready_i  input  1  consumer accepts sum
- sum_o  output  WIDTH  final sum
- count_o  output  CNT_W  terms in the current/last sequence, saturating
- err_o  output  1  illegal function code seen in the current sequence

Behaviour:
- Function encodings: 2'd0 unsigned, 2'd1 ones' complement, 2'd2 two's complement. 2'd3 is illegal: it is latched as 2'd0 and sets err_o.
- Reset (clk edge with rst=1): state IDLE; acc_q, b_q, f_q, count_o, err_o, sum_valid_o all cleared to 0. op_ready_o=1 in the first cycle after reset.
- Reset mid-operation: any state returns to IDLE and any in-flight sum is discarded. The adder is reset on the same rst.
- Outputs are Moore: all outputs are driven from registers or state only. add_a_o=acc_q, add_b_o=b_q, add_f_o=f_q at all times.
- FSM states: IDLE, ACCEPT, ADD, WAIT, DONE.
- IDLE:
  - op_ready_o=1.
  - On op_valid_i: acc_q<=op_i (the first term bypasses the adder, so ones'-complement +0 errors are avoided), f_q<=f_i (mapped), err_o<=(f_i==3), count_o<=1.
  - Next state is DONE if op_last_i, else ACCEPT.
- ACCEPT:
  - op_ready_o=1.
  - On op_valid_i: b_q<=op_i, last_q<=op_last_i, count_o<=count_o+1 (saturating at 2^CNT_W-1). Next state ADD.
  - f_i is ignored.
- ADD: op_ready_o=0. The adder samples acc_q/b_q/f_q at the end of this cycle. Next state WAIT.
- WAIT: op_ready_o=0. add_y_i now holds the result; acc_q<=add_y_i. Next state DONE if last_q, else ACCEPT.
- DONE:
  - sum_valid_o=1, sum_o=acc_q, op_ready_o=0.
  - On sum_ready_i: next state IDLE, sum_valid_o drops the following cycle.
  - Holds indefinitely under backpressure, with sum_o stable.
- Timing:
  - Each non-first term costs 3 cycles (ACCEPT, ADD, WAIT).
  - sum_valid_o rises 3 cycles after the accepting edge of a non-first last term.
  - sum_valid_o rises 1 cycle after a single-term sequence is accepted.
- Arithmetic: all results are the adder's modulo-2^WIDTH results. Overflow is not flagged.
- Hold values: count_o and err_o hold their values through DONE and IDLE until the next first-term acceptance. sum_o holds acc_q after the handshake.
- Simultaneous events: rst has priority over every handshake. A first term cannot be accepted in the same cycle that DONE completes; IDLE is always entered first.

Test Plan:
- f_i=0, terms 3, 5, 7(last), WIDTH=4 -> sum_o=4'hF, count_o=3, err_o=0; sum_valid_o rises 3 cycles after the 7 is accepted.
- f_i=0, terms 9, 9(last) -> sum_o=4'h2 (wrap), count_o=2.
- f_i=2, terms 4'hD, 4'h2(last) -> sum_o=4'hF. f_i=1, terms 4'hE, 4'h3(last) -> sum_o=4'h2.
- Single term 4'hA with op_last_i=1 -> sum_valid_o=1 on the next cycle, sum_o=4'hA; add_b_o is not updated.
- sum_ready_i held low 10 cycles in DONE -> sum_valid_o=1 and sum_o stable throughout, op_ready_o=0. f_i=3 on the first term -> add_f_o=0, err_o=1.
- rst asserted during ADD of a 3-term sequence -> next cycle IDLE, op_ready_o=1, sum_valid_o=0, count_o=0. A fresh sequence 1, 2(last) then gives sum_o=3.
